// File: rtl/soc_i2c_target.sv
// I2C target (7-bit address) with an Avalon-MM register interface.
// SCL/SDA are synchronized; SDA is driven open-drain through sda_oe.
module soc_i2c_target #(
    parameter logic [6:0] ADDR7       = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] RX        = 3'd3;
    localparam logic [2:0] RX_ACK    = 3'd4;
    localparam logic [2:0] TX        = 3'd5;
    localparam logic [2:0] TX_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
    logic       sclPrev_q, sdaPrev_q;
    logic [2:0] state_q, state_d;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] txShift_q, txShift_d;
    logic       sdaOe_q, sdaOe_d;
    logic       busy_q, busy_d;
    logic       ackPhase_q, ackPhase_d;
    logic       rw_q, rw_d;
    logic [7:0] rxData_q, txData_q;
    logic       rxValid_q, overrun_q, nackSeen_q, enable_q;
    logic [31:0] readdata_q, rdMux;
    logic       storeByte, setOverrun, setNack;

    wire sclS     = sclSync_q[SYNC_STAGES-1];
    wire sdaS     = sdaSync_q[SYNC_STAGES-1];
    wire sclRise  = sclS & ~sclPrev_q;
    wire sclFall  = ~sclS & sclPrev_q;
    wire startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    wire stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;

    wire wrStrobe    = chipselect & ~write_n;
    wire rdClear     = chipselect & ~read_n & (address == 2'd0);
    wire rxValidEff  = rxValid_q & ~rdClear;
    wire [7:0] rxByte = {shift_q[6:0], sdaS};
    wire unusedWdata = ^writedata[31:8];

    assign readdata = readdata_q;
    // Gating with enable releases SDA as soon as the block is disabled.
    assign sda_oe   = sdaOe_q & enable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
            sclPrev_q <= sclS;
            sdaPrev_q <= sdaS;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        txShift_d  = txShift_q;
        sdaOe_d    = sdaOe_q;
        busy_d     = busy_q;
        ackPhase_d = ackPhase_q;
        rw_d       = rw_q;
        storeByte  = 1'b0;
        setOverrun = 1'b0;
        setNack    = 1'b0;
        if (!enable_q) begin
            state_d = IDLE;
            sdaOe_d = 1'b0;
            busy_d  = 1'b0;
        end else if (startDet) begin
            state_d  = ADDR;
            bitCnt_d = 4'd0;
            busy_d   = 1'b1;
            sdaOe_d  = 1'b0;
        end else if (stopDet) begin
            state_d = IDLE;
            sdaOe_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (sclRise) begin
                    shift_d = rxByte;
                    if (bitCnt_q == 4'd7) begin
                        if (shift_q[6:0] == ADDR7) begin
                            state_d    = ADDR_ACK;
                            rw_d       = sdaS;
                            ackPhase_d = 1'b0;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
                // First falling edge starts the ACK pulse, the second ends it.
                ADDR_ACK, RX_ACK: if (sclFall) begin
                    if (!ackPhase_q) begin
                        sdaOe_d    = 1'b1;
                        ackPhase_d = 1'b1;
                    end else if (state_q == ADDR_ACK && rw_q) begin
                        state_d   = TX;
                        sdaOe_d   = ~txData_q[7];
                        txShift_d = {txData_q[6:0], 1'b0};
                        bitCnt_d  = 4'd1;
                    end else begin
                        state_d  = RX;
                        sdaOe_d  = 1'b0;
                        bitCnt_d = 4'd0;
                    end
                end
                RX: if (sclRise) begin
                    shift_d = rxByte;
                    if (bitCnt_q == 4'd7) begin
                        if (!rxValidEff) begin
                            storeByte  = 1'b1;
                            state_d    = RX_ACK;
                            ackPhase_d = 1'b0;
                        end else begin
                            setOverrun = 1'b1;
                            state_d    = WAIT_STOP;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
                TX: if (sclFall) begin
                    if (bitCnt_q == 4'd8) begin
                        sdaOe_d = 1'b0;
                        state_d = TX_ACK;
                    end else begin
                        sdaOe_d   = ~txShift_q[7];
                        txShift_d = {txShift_q[6:0], 1'b0};
                        bitCnt_d  = bitCnt_q + 4'd1;
                    end
                end
                TX_ACK: if (sclRise) begin
                    if (!sdaS) begin
                        state_d   = TX;
                        txShift_d = txData_q;
                        bitCnt_d  = 4'd0;
                    end else begin
                        setNack = 1'b1;
                        state_d = WAIT_STOP;
                    end
                end
                WAIT_STOP: sdaOe_d = 1'b0;
                default: begin
                    state_d = IDLE;
                    sdaOe_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdMux = 32'd0;
        case (address)
            2'd0: rdMux = {23'd0, rxValid_q, rxData_q};
            2'd1: rdMux = {24'd0, txData_q};
            2'd2: rdMux = {28'd0, nackSeen_q, busy_q, overrun_q, rxValid_q};
            default: rdMux = {31'd0, enable_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 8'd0;
            txShift_q  <= 8'd0;
            sdaOe_q    <= 1'b0;
            busy_q     <= 1'b0;
            ackPhase_q <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            txShift_q  <= txShift_d;
            sdaOe_q    <= sdaOe_d;
            busy_q     <= busy_d;
            ackPhase_q <= ackPhase_d;
            rw_q       <= rw_d;
        end
    end

    // Bus-side events take priority over the W1C / read-clear of the same flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxData_q   <= 8'd0;
            txData_q   <= 8'd0;
            rxValid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            nackSeen_q <= 1'b0;
            enable_q   <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            readdata_q <= rdMux;
            if (storeByte) begin
                rxData_q  <= rxByte;
                rxValid_q <= 1'b1;
            end else if (rdClear) begin
                rxValid_q <= 1'b0;
            end
            if (setOverrun)
                overrun_q <= 1'b1;
            else if (wrStrobe && address == 2'd2 && writedata[1])
                overrun_q <= 1'b0;
            if (setNack)
                nackSeen_q <= 1'b1;
            else if (wrStrobe && address == 2'd2 && writedata[3])
                nackSeen_q <= 1'b0;
            if (wrStrobe && address == 2'd1)
                txData_q <= writedata[7:0];
            if (wrStrobe && address == 2'd3)
                enable_q <= writedata[0];
        end
    end

endmodule

// File: doc/soc_i2c_target.md
SOC_I2C_TARGET -- requirements
Module: soc_i2c_target

Interface
REQ-001 Parameter ADDR7, default 7'h42: 7-bit I2C target address the block responds to.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on scl_in and sda_in, minimum 2.
REQ-003 clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM register select.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 read_n  input  1  Avalon-MM read strobe, active-low; used only for read side effects.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, registered.
REQ-011 scl_in  input  1  I2C clock line from the bus pad; the block never drives SCL.
REQ-012 sda_in  input  1  I2C data line from the bus pad.
REQ-013 sda_oe  output  1  open-drain pull-down enable; 1 drives SDA low, 0 releases SDA.

Function
REQ-014 Register map:
- 0 RXDATA (RO): [7:0] last received byte, [8] rx_valid.
- 1 TXDATA (RW): [7:0] byte to transmit.
- 2 STATUS: [0] rx_valid, [1] overrun (W1C), [2] busy, [3] nack_seen (W1C).
- 3 CONTROL (RW): [0] enable.
- Unused bits read 0.
REQ-015 readdata SHALL be registered every clk cycle from the mux selected by address (one-cycle latency, independent of chipselect); a write to a register takes effect in the cycle after the write strobe.
REQ-016 A read of RXDATA (chipselect=1, read_n=0, address=0) SHALL clear rx_valid on the next clock edge.
- If a new byte completes in the same cycle, the new byte is stored and rx_valid stays 1.
REQ-017 scl_in and sda_in SHALL pass through SYNC_STAGES flops; all edge detection uses only the synchronized signals.
REQ-018 START = synchronized SDA falls while synchronized SCL is 1; STOP = synchronized SDA rises while SCL is 1.
REQ-019 FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-020 START in any state while enable=1 SHALL enter ADDR, clear the bit counter, set busy=1 and release SDA; a repeated START is handled the same way.
REQ-021 STOP in any state SHALL enter IDLE, set sda_oe=0 and busy=0.
REQ-022 ADDR: shift SDA MSB-first on each SCL rising edge; after 8 bits, compare [7:1] with ADDR7.
- Match: go to ADDR_ACK.
- Mismatch: go to WAIT_STOP with sda_oe=0.
REQ-023 ACK timing (all *_ACK states driven by the target): sda_oe=1 from the SCL falling edge after the 8th bit until the next SCL falling edge, then sda_oe=0.
REQ-024 ADDR_ACK exit: R/W=0 goes to RX; R/W=1 loads TXDATA into the TX shift register and goes to TX.
REQ-025 RX: shift 8 bits on SCL rising edges.
- If rx_valid=0: store the byte in RXDATA, set rx_valid, ACK in RX_ACK, return to RX.
- If rx_valid=1: discard the byte, set overrun, do not drive SDA during the ACK slot (NACK), go to WAIT_STOP.
REQ-026 TX: on each SCL falling edge (the first one is the edge that ends ADDR_ACK or TX_ACK), sda_oe = NOT current bit, MSB first; after the 8th bit's falling edge, sda_oe=0 and go to TX_ACK.
REQ-027 TX_ACK: sample SDA on the SCL rising edge.
- 0 (ACK): reload TXDATA and return to TX.
- 1 (NACK): set nack_seen and go to WAIT_STOP.
REQ-028 WAIT_STOP: sda_oe=0; leave only on START or STOP.
REQ-029 enable=0 SHALL force IDLE and sda_oe=0 within one clk cycle and ignore all bus activity; register access stays functional.
REQ-030 A TXDATA write during a transfer SHALL affect only the next reload, not the byte currently being shifted.

Reset
REQ-031 On reset_n=0, asynchronously:
- readdata=0, sda_oe=0, FSM=IDLE.
- RXDATA=0, TXDATA=0, rx_valid=0, overrun=0, nack_seen=0, enable=0, busy=0.
- Synchronizer flops set to 1 (idle bus).
REQ-032 Reset during a transfer SHALL release SDA immediately; the transfer is not resumed after reset deasserts.

Verification
REQ-033 enable=1; master writes 0x84 (addr 0x42, W) then 0x5A, then STOP -> ACK on both bytes; RXDATA reads 0x15A; second read returns 0x05A.
REQ-034 Master writes 0x86 (addr 0x43) -> sda_oe stays 0 for the whole frame; state WAIT_STOP until STOP; rx_valid=0.
REQ-035 TXDATA=0xC3; master sends 0x85, reads one byte, then NACK -> SDA carries 0xC3 MSB-first; nack_seen=1; after STOP busy=0.
REQ-036 Two written bytes 0x11, 0x22 with no RXDATA read between them -> 0x11 ACKed, 0x22 NACKed; RXDATA=0x111; overrun=1; writing STATUS 0x2 clears overrun.
REQ-037 Repeated START after the ACK of 0x84, then 0x85 and a read with ACK, then NACK -> TXDATA is returned twice; no lockup.
REQ-038 reset_n pulsed low while the target is driving an ACK -> sda_oe=0 in the same cycle; all registers at their reset values.
